board_memory: RTL

- Owns the 8x8 game board store.
- Acts as the responder to the view renderer's read interface: the renderer drives view_x/view_y and receives data_out_view.
- Also accepts cell writes from the game controller through a req/ack handshake.
- Performs a piece-count scan on request, used for the winner message.
- Reports a board-changed flag so the controller knows when to assert can_render.

---
 rtl/board_memory_if.sv | 40 ++++
 rtl/board_memory.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/board_memory_if.sv
// board_memory_if
//   Bundles every non-clock signal between the game controller/renderer side
//   (master) and the board store (slave).
//   restart, clear_changed      : board control from the controller
//   view_x, view_y, data_out_view : renderer read port
//   wr_req/wr_x/wr_y/wr_data/wr_ack : controller cell-write handshake
//   count_req/count_done/black_count/white_count : piece-count scan
//   board_ready, board_changed  : board status
interface board_memory_if;
   logic       restart;
   logic [2:0] view_x;
   logic [2:0] view_y;
   logic [3:0] data_out_view;
   logic       wr_req;
   logic [2:0] wr_x;
   logic [2:0] wr_y;
   logic [3:0] wr_data;
   logic       wr_ack;
   logic       count_req;
   logic       count_done;
   logic [6:0] black_count;
   logic [6:0] white_count;
   logic       board_ready;
   logic       board_changed;
   logic       clear_changed;

   modport master (
      output restart, view_x, view_y, wr_req, wr_x, wr_y, wr_data,
             count_req, clear_changed,
      input  data_out_view, wr_ack, count_done, black_count, white_count,
             board_ready, board_changed
   );

   modport slave (
      input  restart, view_x, view_y, wr_req, wr_x, wr_y, wr_data,
             count_req, clear_changed,
      output data_out_view, wr_ack, count_done, black_count, white_count,
             board_ready, board_changed
   );
endinterface

// File: rtl/board_memory.sv
// board_memory
//   8x8 game board store (64 x 4-bit cells, address {y, x}).
//   Ports:
//     clk    : system clock
//     resetn : asynchronous active-low reset
//     bus    : board_memory_if.slave (view read, cell write handshake,
//              piece-count scan, ready/changed status)
//
//   state | meaning
//   INIT  | load the initial pattern, one cell per cycle, index 0..63
//   IDLE  | arbitrate restart > wr_req > count_req
//   WRITE | commit the requested cell, wr_ack high this cycle
//   COUNT | scan one cell per cycle, index 0..63, then publish totals
module board_memory #(
   parameter int         INIT_CYCLES = 64,
   parameter logic [3:0] EMPTY       = 4'd0,
   parameter logic [3:0] BLACK       = 4'd1,
   parameter logic [3:0] WHITE       = 4'd2
) (
   input logic          clk,
   input logic          resetn,
   board_memory_if.slave bus
);

   typedef enum logic [1:0] {INIT, IDLE, WRITE, COUNT} state_t;

   localparam logic [5:0] LAST_IDX = 6'(INIT_CYCLES - 1);

   state_t     state, state_nxt;
   logic [5:0] idx, idx_nxt;
   logic [3:0] cells [64];
   logic [3:0] view_q;
   logic [3:0] scan_cell;
   logic [6:0] black_acc, white_acc;
   logic [6:0] black_sum, white_sum;
   logic [6:0] black_q, white_q;
   logic       count_done_q;
   logic       changed_q;
   logic       changed_set;

   function automatic logic [3:0] init_cell(input logic [5:0] a);
      logic [2:0] x;
      logic [2:0] y;
      x = a[2:0];
      y = a[5:3];
      if ((x == 3'd3 && y == 3'd3) || (x == 3'd4 && y == 3'd4))
         return WHITE;
      else if ((x == 3'd4 && y == 3'd3) || (x == 3'd3 && y == 3'd4))
         return BLACK;
      else
         return EMPTY;
   endfunction

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= INIT;
         idx   <= 6'd0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   // A count_req still high while count_done is shown belongs to the scan
   // just finished, so it is not taken as a new request.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      case (state)
         INIT: begin
            idx_nxt = idx + 6'd1;
            if (idx == LAST_IDX) state_nxt = IDLE;
         end
         IDLE: begin
            if (bus.restart) begin
               state_nxt = INIT;
               idx_nxt   = 6'd0;
            end else if (bus.wr_req) begin
               state_nxt = WRITE;
            end else if (bus.count_req && !count_done_q) begin
               state_nxt = COUNT;
               idx_nxt   = 6'd0;
            end
         end
         WRITE: state_nxt = IDLE;
         COUNT: begin
            idx_nxt = idx + 6'd1;
            if (idx == LAST_IDX) state_nxt = IDLE;
         end
         default: state_nxt = INIT;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < 64; i++) cells[i] <= EMPTY;
         view_q <= 4'd0;
      end else begin
         view_q <= cells[{bus.view_y, bus.view_x}];
         if (state == INIT)
            cells[idx] <= init_cell(idx);
         else if (state == WRITE)
            cells[{bus.wr_y, bus.wr_x}] <= bus.wr_data;
      end
   end

   assign scan_cell = cells[idx];
   assign black_sum = black_acc + {6'd0, scan_cell == BLACK};
   assign white_sum = white_acc + {6'd0, scan_cell == WHITE};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         black_acc    <= 7'd0;
         white_acc    <= 7'd0;
         black_q      <= 7'd0;
         white_q      <= 7'd0;
         count_done_q <= 1'b0;
      end else begin
         count_done_q <= 1'b0;
         if (state == IDLE && state_nxt == COUNT) begin
            black_acc <= 7'd0;
            white_acc <= 7'd0;
         end else if (state == COUNT) begin
            black_acc <= black_sum;
            white_acc <= white_sum;
            if (idx == LAST_IDX) begin
               black_q      <= black_sum;
               white_q      <= white_sum;
               count_done_q <= 1'b1;
            end
         end
      end
   end

   assign changed_set = (state == WRITE) || (state == INIT && idx == LAST_IDX);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         changed_q <= 1'b0;
      else if (changed_set)
         changed_q <= 1'b1;
      else if (bus.clear_changed)
         changed_q <= 1'b0;
   end

   assign bus.data_out_view = view_q;
   assign bus.wr_ack        = (state == WRITE);
   assign bus.count_done    = count_done_q;
   assign bus.black_count   = black_q;
   assign bus.white_count   = white_q;
   assign bus.board_ready   = (state != INIT);
   assign bus.board_changed = changed_q;

endmodule
